cvxif_result_fifo: RTL and testbench

Result buffer between the coprocessor ALU and the CV-X-IF result interface. It captures every ALU result and holds it until the CPU accepts it with `result_ready_i`, so results are not lost under CPU back-pressure. It drops results whose instruction the CPU kills through the commit interface. It also reports occupancy so the issue stage can deassert `issue_ready` before the buffer overflows.

---
 rtl/cvxif_result_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_cvxif_result_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_result_fifo.sv
// ============================================================================
// cvxif_result_fifo
//
// Holds coprocessor ALU results until the CPU accepts them on the CV-X-IF
// result interface. The ALU has no ready signal, so every result it produces
// is captured here. A result stays in the buffer while the CPU holds off
// result_ready_i.
//
// If the CPU kills an instruction through the commit interface, its buffered
// results are marked killed. Killed entries are never offered. When one
// reaches the head, it is popped silently.
//
// The occupancy count and the almost-full flag let the issue stage stall
// before the buffer overflows. A push that arrives while the buffer is full
// and nothing pops is dropped, and it sets a sticky overflow flag.
//
// Optional feature (macro CVXIF_RESULT_FIFO_BYPASS_EN):
//   When the buffer is empty, a live ALU result is presented combinationally
//   in the same cycle. If the CPU accepts it in that cycle, it is never
//   stored. Without the macro, no combinational path runs from alu_*_i to
//   result_*_o.
//
// Parameters:
//   Depth       - number of entries (power of two, >= 2)
//   XLEN        - result data width
//   IdWidth     - instruction id width
//   HartidWidth - hart id width
//
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   alu_valid_i              - ALU result present this cycle
//   alu_hartid_i/id_i/data_i/rd_i/we_i - ALU result fields
//   commit_valid_i           - commit transaction valid
//   commit_id_i              - id being committed or killed
//   commit_kill_i            - kill the named instruction
//   result_valid_o           - result offered to the CPU
//   result_ready_i           - CPU accepts the offered result
//   result_hartid_o/id_o/data_o/rd_o/we_o - offered result fields (0 when empty)
//   count_o                  - occupied entries, killed ones included
//   almost_full_o            - count_o >= Depth-1
//   overflow_o               - sticky: a push was dropped on a full buffer
// ============================================================================
module cvxif_result_fifo #(
    parameter int Depth       = 4,
    parameter int XLEN        = 32,
    parameter int IdWidth     = 4,
    parameter int HartidWidth = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   alu_valid_i,
    input  logic [HartidWidth-1:0] alu_hartid_i,
    input  logic [IdWidth-1:0]     alu_id_i,
    input  logic [XLEN-1:0]        alu_data_i,
    input  logic [4:0]             alu_rd_i,
    input  logic                   alu_we_i,
    input  logic                   commit_valid_i,
    input  logic [IdWidth-1:0]     commit_id_i,
    input  logic                   commit_kill_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [HartidWidth-1:0] result_hartid_o,
    output logic [IdWidth-1:0]     result_id_o,
    output logic [XLEN-1:0]        result_data_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   almost_full_o,
    output logic                   overflow_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    // Entry storage
    logic [HartidWidth-1:0] r_hartid [Depth];
    logic [IdWidth-1:0]     r_id     [Depth];
    logic [XLEN-1:0]        r_data   [Depth];
    logic [4:0]             r_rd     [Depth];
    logic [Depth-1:0]       r_we;
    logic [Depth-1:0]       r_killed;
    // Per-entry occupancy. The kill scan uses it so it only marks live entries.
    logic [Depth-1:0]       r_occ;

    logic [PtrW-1:0]        r_rdPtr;
    logic [PtrW-1:0]        r_wrPtr;
    logic [CntW-1:0]        r_count;
    logic                   r_almostFull;
    logic                   r_overflow;

    logic                   w_empty;
    logic                   w_full;
    logic                   w_headKilled;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_killReq;
    logic                   w_pushKilled;
    logic                   w_bypassTaken;
    logic [CntW-1:0]        w_countNext;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CntW'(Depth));
    assign w_headKilled = r_killed[r_rdPtr];

    // A killed head leaves without a handshake. A live head leaves when the
    // CPU accepts it. Only a non-empty buffer can pop.
    assign w_pop = !w_empty && (w_headKilled || result_ready_i);

    assign w_killReq    = commit_valid_i && commit_kill_i;
    assign w_pushKilled = w_killReq && (commit_id_i == alu_id_i);

`ifdef CVXIF_RESULT_FIFO_BYPASS_EN
    logic w_bypass;
    // Present a live result straight through only when nothing is queued
    // ahead of it.
    assign w_bypass      = w_empty && alu_valid_i && !w_pushKilled;
    assign w_bypassTaken = w_bypass && result_ready_i;
`else
    assign w_bypassTaken = 1'b0;
`endif

    // A full buffer can still accept a push when the head leaves in the same
    // cycle, because the freed slot is the one being written.
    assign w_push = alu_valid_i && (!w_full || w_pop) && !w_bypassTaken;

    assign w_countNext = r_count + {{(CntW-1){1'b0}}, w_push}
                                 - {{(CntW-1){1'b0}}, w_pop};

    // Storage, pointers and status registers. The kill scan runs first.
    // The push write comes after it, so a slot freed and refilled in the
    // same cycle takes the new entry's kill flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                r_hartid[i] <= '0;
                r_id[i]     <= '0;
                r_data[i]   <= '0;
                r_rd[i]     <= '0;
            end
            r_we         <= '0;
            r_killed     <= '0;
            r_occ        <= '0;
            r_rdPtr      <= '0;
            r_wrPtr      <= '0;
            r_count      <= '0;
            r_almostFull <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (w_killReq && r_occ[i] && (r_id[i] == commit_id_i)) begin
                    r_killed[i] <= 1'b1;
                end
            end
            if (w_pop) begin
                r_occ[r_rdPtr] <= 1'b0;
                r_rdPtr        <= r_rdPtr + PtrW'(1);
            end
            if (w_push) begin
                r_hartid[r_wrPtr] <= alu_hartid_i;
                r_id[r_wrPtr]     <= alu_id_i;
                r_data[r_wrPtr]   <= alu_data_i;
                r_rd[r_wrPtr]     <= alu_rd_i;
                r_we[r_wrPtr]     <= alu_we_i;
                r_killed[r_wrPtr] <= w_pushKilled;
                r_occ[r_wrPtr]    <= 1'b1;
                r_wrPtr           <= r_wrPtr + PtrW'(1);
            end
            r_count      <= w_countNext;
            r_almostFull <= (w_countNext >= CntW'(Depth - 1));
            if (alu_valid_i && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // The result interface shows the head entry, even a killed one. A killed
    // head is not marked valid. When the buffer is empty, the fields read as
    // zero, or show the bypassed ALU result if the feature is built in.
    always_comb begin
        result_valid_o  = 1'b0;
        result_hartid_o = '0;
        result_id_o     = '0;
        result_data_o   = '0;
        result_rd_o     = '0;
        result_we_o     = 1'b0;
        if (!w_empty) begin
            result_valid_o  = !w_headKilled;
            result_hartid_o = r_hartid[r_rdPtr];
            result_id_o     = r_id[r_rdPtr];
            result_data_o   = r_data[r_rdPtr];
            result_rd_o     = r_rd[r_rdPtr];
            result_we_o     = r_we[r_rdPtr];
        end
`ifdef CVXIF_RESULT_FIFO_BYPASS_EN
        else if (w_bypass) begin
            result_valid_o  = 1'b1;
            result_hartid_o = alu_hartid_i;
            result_id_o     = alu_id_i;
            result_data_o   = alu_data_i;
            result_rd_o     = alu_rd_i;
            result_we_o     = alu_we_i;
        end
`endif
    end

    assign count_o       = r_count;
    assign almost_full_o = r_almostFull;
    assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_cvxif_result_fifo.sv
// ============================================================================
// tb_cvxif_result_fifo
//
// Directed bench for cvxif_result_fifo at its default sizes (Depth=4,
// XLEN=32, IdWidth=4, HartidWidth=1). The expected values are hand-computed
// constants, plus small helper functions that derive each entry's data, rd
// and we from its id.
// ============================================================================
module tb_cvxif_result_fifo;

    logic        clk;
    logic        rst_n;
    logic        aluValid;
    logic [0:0]  aluHartid;
    logic [3:0]  aluId;
    logic [31:0] aluData;
    logic [4:0]  aluRd;
    logic        aluWe;
    logic        commitValid;
    logic [3:0]  commitId;
    logic        commitKill;
    logic        result_valid_o;
    logic        resultReady;
    logic [0:0]  result_hartid_o;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [2:0]  count_o;
    logic        almost_full_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    logic [3:0] expIds [4];

    cvxif_result_fifo dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .alu_valid_i     (aluValid),
        .alu_hartid_i    (aluHartid),
        .alu_id_i        (aluId),
        .alu_data_i      (aluData),
        .alu_rd_i        (aluRd),
        .alu_we_i        (aluWe),
        .commit_valid_i  (commitValid),
        .commit_id_i     (commitId),
        .commit_kill_i   (commitKill),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (resultReady),
        .result_hartid_o (result_hartid_o),
        .result_id_o     (result_id_o),
        .result_data_o   (result_data_o),
        .result_rd_o     (result_rd_o),
        .result_we_o     (result_we_o),
        .count_o         (count_o),
        .almost_full_o   (almost_full_o),
        .overflow_o      (overflow_o)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload derived from the id, so every entry carries distinct fields
    function automatic logic [31:0] dataOf(input logic [3:0] id);
        return 32'hC0DE_0000 + {28'd0, id};
    endfunction

    function automatic logic [4:0] rdOf(input logic [3:0] id);
        return {1'b0, id} + 5'd1;
    endfunction

    // id 2 carries we=0 so that a non-writing result is also delivered
    function automatic logic weOf(input logic [3:0] id);
        return (id != 4'd2);
    endfunction

    task automatic applyStimulus(input logic v, input logic [3:0] id,
                                 input logic [31:0] data, input logic [4:0] rd,
                                 input logic we, input logic cv,
                                 input logic [3:0] cid, input logic kill,
                                 input logic ready);
        aluValid    = v;
        aluHartid   = 1'b0;
        aluId       = id;
        aluData     = data;
        aluRd       = rd;
        aluWe       = we;
        commitValid = cv;
        commitId    = cid;
        commitKill  = kill;
        resultReady = ready;
    endtask

    task automatic pushId(input logic [3:0] id, input logic ready);
        applyStimulus(1'b1, id, dataOf(id), rdOf(id), weOf(id), 1'b0, 4'd0, 1'b0, ready);
    endtask

    task automatic idle(input logic ready);
        applyStimulus(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0, ready);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Moves to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        expIds[0] = 4'd1;
        expIds[1] = 4'd2;
        expIds[2] = 4'd3;
        expIds[3] = 4'd5;

        rst_n = 1'b0;
        idle(1'b0);
        #12;
        checkOutput("rstValid", result_valid_o, 0);
        checkOutput("rstCount", count_o, 0);
        checkOutput("rstAlmostFull", almost_full_o, 0);
        checkOutput("rstOverflow", overflow_o, 0);
        checkOutput("rstId", result_id_o, 0);
        checkOutput("rstData", result_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifdef CVXIF_RESULT_FIFO_BYPASS_EN
        // Empty buffer, accepted in the same cycle, so the entry is never stored
        applyStimulus(1'b1, 4'd9, 32'h1234_5678, 5'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checkOutput("bypValid", result_valid_o, 1);
        checkOutput("bypId", result_id_o, 9);
        checkOutput("bypData", result_data_o, 32'h1234_5678);
        tick();
        idle(1'b0);
        #1;
        checkOutput("bypCount", count_o, 0);
        checkOutput("bypAfterValid", result_valid_o, 0);
        tick();
`else
        // Single result: one cycle from push to offer
        applyStimulus(1'b1, 4'd3, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checkOutput("t1SameCycleValid", result_valid_o, 0);
        tick();
        idle(1'b1);
        #1;
        checkOutput("t1Valid", result_valid_o, 1);
        checkOutput("t1Id", result_id_o, 3);
        checkOutput("t1Data", result_data_o, 32'hDEAD_BEEF);
        checkOutput("t1Rd", result_rd_o, 5);
        checkOutput("t1We", result_we_o, 1);
        checkOutput("t1Count", count_o, 1);
        tick();
        idle(1'b0);
        #1;
        checkOutput("t1CountAfter", count_o, 0);
        checkOutput("t1ValidAfter", result_valid_o, 0);
        checkOutput("t1EmptyId", result_id_o, 0);
        tick();
`endif

        // Fill to capacity under back-pressure, then overflow
        pushId(4'd0, 1'b0); tick();
        pushId(4'd1, 1'b0); tick();
        pushId(4'd2, 1'b0); tick();
        checkOutput("t2Count3", count_o, 3);
        checkOutput("t2AlmostFull3", almost_full_o, 1);
        pushId(4'd3, 1'b0); tick();
        checkOutput("t2Count4", count_o, 4);
        checkOutput("t2AlmostFull4", almost_full_o, 1);
        checkOutput("t2NoOverflow", overflow_o, 0);
        checkOutput("t2HeadId", result_id_o, 0);
        pushId(4'd4, 1'b0); tick();
        idle(1'b0);
        #1;
        checkOutput("t2Overflow", overflow_o, 1);
        checkOutput("t2CountHeld", count_o, 4);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            #1;
            checkOutput("t2DrainValid", result_valid_o, 1);
            checkOutput("t2DrainId", result_id_o, k);
            checkOutput("t2DrainData", result_data_o, dataOf(4'(k)));
            checkOutput("t2DrainWe", result_we_o, weOf(4'(k)));
            tick();
        end
        idle(1'b0);
        #1;
        checkOutput("t2DrainedCount", count_o, 0);
        checkOutput("t2DrainedValid", result_valid_o, 0);
        checkOutput("t2OverflowSticky", overflow_o, 1);

        // Reset while holding an entry discards it and clears the sticky flag
        pushId(4'd6, 1'b0); tick();
        idle(1'b0);
        #1;
        checkOutput("rsOpValid", result_valid_o, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rsValid", result_valid_o, 0);
        checkOutput("rsCount", count_o, 0);
        checkOutput("rsOverflow", overflow_o, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("rsNoDelivery", result_valid_o, 0);

        // Full buffer with a simultaneous pop and push
        pushId(4'd0, 1'b0); tick();
        pushId(4'd1, 1'b0); tick();
        pushId(4'd2, 1'b0); tick();
        pushId(4'd3, 1'b0); tick();
        pushId(4'd5, 1'b1);
        #1;
        checkOutput("t3Valid", result_valid_o, 1);
        checkOutput("t3Id", result_id_o, 0);
        checkOutput("t3CountBefore", count_o, 4);
        tick();
        idle(1'b1);
        #1;
        checkOutput("t3CountKept", count_o, 4);
        checkOutput("t3Overflow", overflow_o, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            #1;
            checkOutput("t3DrainValid", result_valid_o, 1);
            checkOutput("t3DrainId", result_id_o, expIds[k]);
            tick();
        end
        idle(1'b0);
        #1;
        checkOutput("t3DrainedCount", count_o, 0);

        // Kill of a buffered entry: id 2 is dropped silently
        pushId(4'd1, 1'b0); tick();
        pushId(4'd2, 1'b0); tick();
        applyStimulus(1'b1, 4'd3, dataOf(4'd3), rdOf(4'd3), weOf(4'd3), 1'b1, 4'd2, 1'b1, 1'b0);
        tick();
        idle(1'b1);
        #1;
        checkOutput("t4Count", count_o, 3);
        checkOutput("t4Valid1", result_valid_o, 1);
        checkOutput("t4Id1", result_id_o, 1);
        tick();
        #1;
        checkOutput("t4KilledValid", result_valid_o, 0);
        checkOutput("t4KilledId", result_id_o, 2);
        tick();
        #1;
        checkOutput("t4Valid3", result_valid_o, 1);
        checkOutput("t4Id3", result_id_o, 3);
        tick();
        idle(1'b0);
        #1;
        checkOutput("t4Empty", result_valid_o, 0);
        checkOutput("t4CountEnd", count_o, 0);

        // Kill the offered head while the CPU holds off
        pushId(4'd7, 1'b0); tick();
        applyStimulus(1'b1, 4'd8, dataOf(4'd8), rdOf(4'd8), weOf(4'd8), 1'b1, 4'd7, 1'b0, 1'b0);
        #1;
        checkOutput("t5Head7", result_id_o, 7);
        tick();
        applyStimulus(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        #1;
        checkOutput("t5CommitNoKill", result_valid_o, 1);
        tick();
        idle(1'b0);
        #1;
        checkOutput("t5KilledValid", result_valid_o, 0);
        checkOutput("t5KilledId", result_id_o, 7);
        checkOutput("t5CountBeforeDrop", count_o, 2);
        tick();
        checkOutput("t5NextValid", result_valid_o, 1);
        checkOutput("t5NextId", result_id_o, 8);
        checkOutput("t5CountAfterDrop", count_o, 1);
        idle(1'b1);
        tick();
        idle(1'b0);
        #1;
        checkOutput("t5CountEnd", count_o, 0);

        // Push killed in its own cycle: stored as killed, never offered
        applyStimulus(1'b1, 4'd10, dataOf(4'd10), rdOf(4'd10), 1'b1, 1'b1, 4'd10, 1'b1, 1'b0);
        tick();
        idle(1'b0);
        #1;
        checkOutput("t6Count", count_o, 1);
        checkOutput("t6Valid", result_valid_o, 0);
        tick();
        checkOutput("t6CountEnd", count_o, 0);
        checkOutput("t6ValidEnd", result_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
